bus_master_if: RTL

Initiator-side bus interface paired with the 4-master bus arbiter. It accepts one access from a local core or DMA port and drives the arbiter's request/grant handshake: it asserts the active-low request, waits for the active-low grant, issues one address-strobed read or write, and waits for the slave's active-low ready. It then returns the read data to the core and releases the bus. One instance sits in front of each bus master (m0..m3).

---
 rtl/bus_master_if_pkg.sv | 18 +
 rtl/bus_master_if_watchdog.sv | 28 ++
 rtl/bus_master_if.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bus_master_if_pkg.sv
// Active-low levels, direction encodings and FSM states shared by the
// bus master interface and its watchdog.
package bus_master_if_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    BUS_MST_IDLE   = 2'd0,
    BUS_MST_REQ    = 2'd1,
    BUS_MST_ACCESS = 2'd2,
    BUS_MST_WAIT   = 2'd3
  } bus_mst_state_e;

endpackage

// File: rtl/bus_master_if_watchdog.sv
// WAIT-state timeout counter; only instantiated by bus_master_if when
// BUS_MASTER_TIMEOUT_EN is defined.
module bus_watchdog (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // Fires in the cycle whose increment would reach the limit.
  assign expired = en &&
    (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/bus_master_if.sv
// Initiator-side request/grant/strobe/ready sequencer for one bus master.
// Define BUS_MASTER_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_rw,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_busy,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_limit
    $error("TIMEOUT_CYC must be within 1..255");
  end

  bus_mst_state_e state, state_d;

  logic              req_d;
  logic              as_d;
  logic              rw_d;
  logic              busy_d;
  logic              done_d;
  logic              err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              expired;
  logic              on_bus;
  logic              abort;

`ifdef BUS_MASTER_TIMEOUT_EN
  bus_watchdog u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == BUS_MST_ACCESS),
    .en      (state == BUS_MST_WAIT &&
              bus_rdy_ == DISABLE_),
    .limit   (8'(TIMEOUT_CYC)),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign on_bus = (state == BUS_MST_ACCESS) ||
                  (state == BUS_MST_WAIT);

  // Losing the grant outranks a same-cycle ready.
  assign abort = on_bus &&
    (bus_grnt_ == DISABLE_ || expired);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUS_MST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    req_d   = bus_req_;
    as_d    = bus_as_;
    addr_d  = bus_addr;
    rw_d    = bus_rw;
    wdata_d = bus_wr_data;
    rdata_d = core_rd_data;
    busy_d  = core_busy;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state)
      BUS_MST_IDLE: begin
        if (core_req) begin
          addr_d  = core_addr;
          rw_d    = core_rw;
          wdata_d = core_wr_data;
          req_d   = ENABLE_;
          busy_d  = 1'b1;
          state_d = BUS_MST_REQ;
        end
      end
      BUS_MST_REQ: begin
        if (bus_grnt_ == ENABLE_) begin
          as_d    = ENABLE_;
          state_d = BUS_MST_ACCESS;
        end
      end
      BUS_MST_ACCESS: begin
        as_d    = DISABLE_;
        state_d = BUS_MST_WAIT;
      end
      BUS_MST_WAIT: begin
        if (bus_rdy_ == ENABLE_) begin
          if (bus_rw == READ) begin
            rdata_d = bus_rd_data;
          end
          done_d  = 1'b1;
          req_d   = DISABLE_;
          busy_d  = 1'b0;
          state_d = BUS_MST_IDLE;
        end
      end
      default: state_d = BUS_MST_IDLE;
    endcase

    if (abort) begin
      rdata_d = '0;
      done_d  = 1'b1;
      err_d   = 1'b1;
      req_d   = DISABLE_;
      as_d    = DISABLE_;
      busy_d  = 1'b0;
      state_d = BUS_MST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req_     <= DISABLE_;
      bus_as_      <= DISABLE_;
      bus_rw       <= READ;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
      core_busy    <= 1'b0;
      core_done    <= 1'b0;
      core_err     <= 1'b0;
      core_rd_data <= '0;
    end else begin
      bus_req_     <= req_d;
      bus_as_      <= as_d;
      bus_rw       <= rw_d;
      bus_addr     <= addr_d;
      bus_wr_data  <= wdata_d;
      core_busy    <= busy_d;
      core_done    <= done_d;
      core_err     <= err_d;
      core_rd_data <= rdata_d;
    end
  end

endmodule
